reg_issue_ctrl: RTL and testbench

REG_ISSUE_CTRL -- requirements
Module: reg_issue_ctrl

---
 rtl/reg_issue_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_reg_issue_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_issue_ctrl.sv
// reg_issue_ctrl -- dual-lane register issue stage with scoreboard stalls.
//
// Lanes A and B present one instruction each. The stage reads operands from
// a register file that forwards same-cycle writebacks. Stalls come from a
// per-register scoreboard that counts down after each register write.
// Direct register assignments and bank-pointer ops are executed here, then
// retired downstream as NOPs. Everything else is passed through with a
// one-cycle latency.
//
// Ports:
//   clock_i, reset_i                 clock, async active-high reset
//   validx/pwritex/preadx/sreadx_i   per-lane instruction qualifiers
//   functionTypex/opcodex_i          per-lane instruction code
//   primAddrx_i, secOperandx_i       primary register, secondary operand/register
//   flush_i                          synchronous flush of both lanes
//   wbx_i, wbAddrx_i, wbDatax_i      per-lane register writeback
//   stallx_o                         combinational per-lane hold request
//   validx_o ... secValx_o           registered per-lane issue outputs
//   bank_o                           register bank pointer
module reg_issue_ctrl #(
  parameter int DATA_W      = 16,
  parameter int REG_ADDR_W  = 5,
  parameter int BANK_W      = 6,
  parameter int STALL_DELAY = 6,
  parameter int CTR_W       = 3
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  validA_i,
  input  logic                  pwriteA_i,
  input  logic                  preadA_i,
  input  logic                  sreadA_i,
  input  logic [1:0]            functionTypeA_i,
  input  logic [6:0]            opcodeA_i,
  input  logic [REG_ADDR_W-1:0] primAddrA_i,
  input  logic [DATA_W-1:0]     secOperandA_i,
  input  logic                  validB_i,
  input  logic                  pwriteB_i,
  input  logic                  preadB_i,
  input  logic                  sreadB_i,
  input  logic [1:0]            functionTypeB_i,
  input  logic [6:0]            opcodeB_i,
  input  logic [REG_ADDR_W-1:0] primAddrB_i,
  input  logic [DATA_W-1:0]     secOperandB_i,
  input  logic                  flush_i,
  input  logic                  wbA_i,
  input  logic [REG_ADDR_W-1:0] wbAddrA_i,
  input  logic [DATA_W-1:0]     wbDataA_i,
  input  logic                  wbB_i,
  input  logic [REG_ADDR_W-1:0] wbAddrB_i,
  input  logic [DATA_W-1:0]     wbDataB_i,
  output logic                  stallA_o,
  output logic                  stallB_o,
  output logic                  validA_o,
  output logic                  wbA_o,
  output logic [6:0]            opcodeA_o,
  output logic [1:0]            functionTypeA_o,
  output logic [REG_ADDR_W-1:0] regAddrA_o,
  output logic [DATA_W-1:0]     primValA_o,
  output logic [DATA_W-1:0]     secValA_o,
  output logic                  validB_o,
  output logic                  wbB_o,
  output logic [6:0]            opcodeB_o,
  output logic [1:0]            functionTypeB_o,
  output logic [REG_ADDR_W-1:0] regAddrB_o,
  output logic [DATA_W-1:0]     primValB_o,
  output logic [DATA_W-1:0]     secValB_o,
  output logic [BANK_W-1:0]     bank_o
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam logic [CTR_W-1:0]  CNT_ZERO = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0]  CNT_LOAD = CTR_W'(STALL_DELAY);
  localparam logic [CTR_W-1:0]  CNT_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [BANK_W-1:0] BANK_ZERO = {BANK_W{1'b0}};
  localparam logic [BANK_W-1:0] BANK_INC  = {{(BANK_W-1){1'b0}}, 1'b1};
  localparam logic [BANK_W-1:0] BANK_DEC  = {BANK_W{1'b1}};

  logic [DATA_W-1:0] rf_r       [NREG];
  logic [CTR_W-1:0]  scoreCnt_r [NREG];
  logic [BANK_W-1:0] bank_r;

  // Register read with writeback bypass; lane B's writeback is the younger one.
  function automatic logic [DATA_W-1:0] fwdRead(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [DATA_W-1:0]     rfVal,
    input logic                  wbAv,
    input logic [REG_ADDR_W-1:0] wbAaddr,
    input logic [DATA_W-1:0]     wbAdata,
    input logic                  wbBv,
    input logic [REG_ADDR_W-1:0] wbBaddr,
    input logic [DATA_W-1:0]     wbBdata
  );
    if (wbBv && (wbBaddr == addr)) begin
      return wbBdata;
    end else if (wbAv && (wbAaddr == addr)) begin
      return wbAdata;
    end else begin
      return rfVal;
    end
  endfunction

  logic [REG_ADDR_W-1:0] secAddrA_s, secAddrB_s;
  logic hazardA_s, hazardB_s, conflict_s;
  logic acceptA_s, acceptB_s;
  logic isAssignA_s, isAssignB_s, isBankA_s, isBankB_s;
  logic assignA_s, assignB_s, loadA_s, loadB_s;
  logic [DATA_W-1:0] primValA_s, primValB_s, secValA_s, secValB_s;
  logic [BANK_W-1:0] deltaA_s, deltaB_s;

  assign secAddrA_s = secOperandA_i[REG_ADDR_W-1:0];
  assign secAddrB_s = secOperandB_i[REG_ADDR_W-1:0];

  assign hazardA_s = validA_i &
                     ((preadA_i & (scoreCnt_r[primAddrA_i] != CNT_ZERO)) |
                      (sreadA_i & (scoreCnt_r[secAddrA_s] != CNT_ZERO)));
  assign hazardB_s = validB_i &
                     ((preadB_i & (scoreCnt_r[primAddrB_i] != CNT_ZERO)) |
                      (sreadB_i & (scoreCnt_r[secAddrB_s] != CNT_ZERO)));
  // B must not overtake an A that writes a register B touches.
  assign conflict_s = validA_i & pwriteA_i & validB_i &
                      ((((preadB_i | pwriteB_i) & (primAddrB_i == primAddrA_i))) |
                       (sreadB_i & (secAddrB_s == primAddrA_i)));

  // Reset gating keeps the purely input-driven conflict term quiet in reset.
  assign stallA_o = ~reset_i & ~flush_i & hazardA_s;
  assign stallB_o = ~reset_i & ~flush_i & (hazardA_s | hazardB_s | conflict_s);

  assign acceptA_s = validA_i & ~flush_i & ~hazardA_s;
  assign acceptB_s = validB_i & ~flush_i & ~(hazardA_s | hazardB_s | conflict_s);

  assign isAssignA_s = (functionTypeA_i == 2'd1) & pwriteA_i &
                       ((opcodeA_i == 7'd0) | (opcodeA_i == 7'd10));
  assign isAssignB_s = (functionTypeB_i == 2'd1) & pwriteB_i &
                       ((opcodeB_i == 7'd0) | (opcodeB_i == 7'd10));
  assign isBankA_s = (functionTypeA_i == 2'd3) & ((opcodeA_i == 7'd20) | (opcodeA_i == 7'd21));
  assign isBankB_s = (functionTypeB_i == 2'd3) & ((opcodeB_i == 7'd20) | (opcodeB_i == 7'd21));

  assign assignA_s = acceptA_s & isAssignA_s;
  assign assignB_s = acceptB_s & isAssignB_s;
  assign loadA_s   = acceptA_s & pwriteA_i & ~isAssignA_s & ~isBankA_s;
  assign loadB_s   = acceptB_s & pwriteB_i & ~isAssignB_s & ~isBankB_s;

  assign primValA_s = preadA_i ? fwdRead(primAddrA_i, rf_r[primAddrA_i], wbA_i, wbAddrA_i,
                                         wbDataA_i, wbB_i, wbAddrB_i, wbDataB_i) : DATA_ZERO;
  assign primValB_s = preadB_i ? fwdRead(primAddrB_i, rf_r[primAddrB_i], wbA_i, wbAddrA_i,
                                         wbDataA_i, wbB_i, wbAddrB_i, wbDataB_i) : DATA_ZERO;
  assign secValA_s  = sreadA_i ? fwdRead(secAddrA_s, rf_r[secAddrA_s], wbA_i, wbAddrA_i,
                                         wbDataA_i, wbB_i, wbAddrB_i, wbDataB_i) : secOperandA_i;
  assign secValB_s  = sreadB_i ? fwdRead(secAddrB_s, rf_r[secAddrB_s], wbA_i, wbAddrA_i,
                                         wbDataA_i, wbB_i, wbAddrB_i, wbDataB_i) : secOperandB_i;

  // Bank pointer step contributed by each accepted bank op (-1 as all ones).
  always_comb begin
    deltaA_s = BANK_ZERO;
    deltaB_s = BANK_ZERO;
    if (acceptA_s && isBankA_s) begin
      if (opcodeA_i == 7'd20) deltaA_s = BANK_INC;
      else                    deltaA_s = BANK_DEC;
    end else begin
      deltaA_s = BANK_ZERO;
    end
    if (acceptB_s && isBankB_s) begin
      if (opcodeB_i == 7'd20) deltaB_s = BANK_INC;
      else                    deltaB_s = BANK_DEC;
    end else begin
      deltaB_s = BANK_ZERO;
    end
  end

  // Register file: later assignments win, giving wbA < wbB < assignA < assignB.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) rf_r[i] <= DATA_ZERO;
    end else begin
      if (wbA_i)     rf_r[wbAddrA_i]   <= wbDataA_i;
      if (wbB_i)     rf_r[wbAddrB_i]   <= wbDataB_i;
      if (assignA_s) rf_r[primAddrA_i] <= secValA_s;
      if (assignB_s) rf_r[primAddrB_i] <= secValB_s;
    end
  end

  // Scoreboard counters: load beats writeback clear, which beats countdown.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) scoreCnt_r[i] <= CNT_ZERO;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if ((loadA_s && (primAddrA_i == REG_ADDR_W'(i))) ||
            (loadB_s && (primAddrB_i == REG_ADDR_W'(i)))) begin
          scoreCnt_r[i] <= CNT_LOAD;
        end else if ((wbA_i && (wbAddrA_i == REG_ADDR_W'(i))) ||
                     (wbB_i && (wbAddrB_i == REG_ADDR_W'(i)))) begin
          scoreCnt_r[i] <= CNT_ZERO;
        end else if (scoreCnt_r[i] != CNT_ZERO) begin
          scoreCnt_r[i] <= scoreCnt_r[i] - CNT_ONE;
        end else begin
          scoreCnt_r[i] <= scoreCnt_r[i];
        end
      end
    end
  end

  // Bank pointer wraps naturally at BANK_W bits.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) bank_r <= BANK_ZERO;
    else         bank_r <= bank_r + deltaA_s + deltaB_s;
  end
  assign bank_o = bank_r;

  // Lane A issue register; executed assignments/bank ops retire as NOPs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      {validA_o, wbA_o, opcodeA_o, functionTypeA_o, regAddrA_o} <= '0;
      primValA_o <= DATA_ZERO;
      secValA_o  <= DATA_ZERO;
    end else if (acceptA_s) begin
      validA_o   <= 1'b1;
      primValA_o <= primValA_s;
      secValA_o  <= secValA_s;
      if (isAssignA_s || isBankA_s) begin
        {wbA_o, opcodeA_o, functionTypeA_o, regAddrA_o} <= '0;
      end else begin
        wbA_o           <= pwriteA_i;
        opcodeA_o       <= opcodeA_i;
        functionTypeA_o <= functionTypeA_i;
        regAddrA_o      <= primAddrA_i;
      end
    end else begin
      {validA_o, wbA_o, opcodeA_o, functionTypeA_o, regAddrA_o} <= '0;
      primValA_o <= DATA_ZERO;
      secValA_o  <= DATA_ZERO;
    end
  end

  // Lane B issue register; same retirement rules as lane A.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      {validB_o, wbB_o, opcodeB_o, functionTypeB_o, regAddrB_o} <= '0;
      primValB_o <= DATA_ZERO;
      secValB_o  <= DATA_ZERO;
    end else if (acceptB_s) begin
      validB_o   <= 1'b1;
      primValB_o <= primValB_s;
      secValB_o  <= secValB_s;
      if (isAssignB_s || isBankB_s) begin
        {wbB_o, opcodeB_o, functionTypeB_o, regAddrB_o} <= '0;
      end else begin
        wbB_o           <= pwriteB_i;
        opcodeB_o       <= opcodeB_i;
        functionTypeB_o <= functionTypeB_i;
        regAddrB_o      <= primAddrB_i;
      end
    end else begin
      {validB_o, wbB_o, opcodeB_o, functionTypeB_o, regAddrB_o} <= '0;
      primValB_o <= DATA_ZERO;
      secValB_o  <= DATA_ZERO;
    end
  end

endmodule

// File: tb/tb_reg_issue_ctrl.sv
// Scoreboard bench for reg_issue_ctrl: stimulus pushes expected issue
// records per lane, a negedge monitor pops and compares them whenever a
// lane presents validx_o. Stall and bank values are checked inline.
module tb_reg_issue_ctrl;

  typedef struct packed {
    logic [6:0]  op;
    logic [1:0]  ft;
    logic [4:0]  addr;
    logic        wb;
    logic [15:0] prim;
    logic [15:0] sec;
  } exp_t;

  logic clock_i = 1'b0;
  logic reset_i;
  logic validA_i, pwriteA_i, preadA_i, sreadA_i;
  logic [1:0] functionTypeA_i;
  logic [6:0] opcodeA_i;
  logic [4:0] primAddrA_i;
  logic [15:0] secOperandA_i;
  logic validB_i, pwriteB_i, preadB_i, sreadB_i;
  logic [1:0] functionTypeB_i;
  logic [6:0] opcodeB_i;
  logic [4:0] primAddrB_i;
  logic [15:0] secOperandB_i;
  logic flush_i;
  logic wbA_i, wbB_i;
  logic [4:0] wbAddrA_i, wbAddrB_i;
  logic [15:0] wbDataA_i, wbDataB_i;
  logic stallA_o, stallB_o;
  logic validA_o, wbA_o, validB_o, wbB_o;
  logic [6:0] opcodeA_o, opcodeB_o;
  logic [1:0] functionTypeA_o, functionTypeB_o;
  logic [4:0] regAddrA_o, regAddrB_o;
  logic [15:0] primValA_o, secValA_o, primValB_o, secValB_o;
  logic [5:0] bank_o;

  int vectors = 0;
  int miscompares = 0;
  exp_t expA[$];
  exp_t expB[$];

  reg_issue_ctrl dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .validA_i(validA_i), .pwriteA_i(pwriteA_i), .preadA_i(preadA_i), .sreadA_i(sreadA_i),
    .functionTypeA_i(functionTypeA_i), .opcodeA_i(opcodeA_i),
    .primAddrA_i(primAddrA_i), .secOperandA_i(secOperandA_i),
    .validB_i(validB_i), .pwriteB_i(pwriteB_i), .preadB_i(preadB_i), .sreadB_i(sreadB_i),
    .functionTypeB_i(functionTypeB_i), .opcodeB_i(opcodeB_i),
    .primAddrB_i(primAddrB_i), .secOperandB_i(secOperandB_i),
    .flush_i(flush_i),
    .wbA_i(wbA_i), .wbAddrA_i(wbAddrA_i), .wbDataA_i(wbDataA_i),
    .wbB_i(wbB_i), .wbAddrB_i(wbAddrB_i), .wbDataB_i(wbDataB_i),
    .stallA_o(stallA_o), .stallB_o(stallB_o),
    .validA_o(validA_o), .wbA_o(wbA_o), .opcodeA_o(opcodeA_o),
    .functionTypeA_o(functionTypeA_o), .regAddrA_o(regAddrA_o),
    .primValA_o(primValA_o), .secValA_o(secValA_o),
    .validB_o(validB_o), .wbB_o(wbB_o), .opcodeB_o(opcodeB_o),
    .functionTypeB_o(functionTypeB_o), .regAddrB_o(regAddrB_o),
    .primValB_o(primValB_o), .secValB_o(secValB_o),
    .bank_o(bank_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented issue must match the oldest expectation.
  always @(negedge clock_i) begin
    if (!reset_i) begin
      if (validA_o) begin
        if (expA.size() == 0) begin
          check("laneA unexpected issue", 64'(opcodeA_o), 64'hFFFF);
        end else begin
          check("laneA issue",
                64'({opcodeA_o, functionTypeA_o, regAddrA_o, wbA_o, primValA_o, secValA_o}),
                64'(expA.pop_front()));
        end
      end
      if (validB_o) begin
        if (expB.size() == 0) begin
          check("laneB unexpected issue", 64'(opcodeB_o), 64'hFFFF);
        end else begin
          check("laneB issue",
                64'({opcodeB_o, functionTypeB_o, regAddrB_o, wbB_o, primValB_o, secValB_o}),
                64'(expB.pop_front()));
        end
      end
    end
  end

  task automatic setA(input logic v, input logic pw, input logic pr, input logic sr,
                      input logic [1:0] ft, input logic [6:0] op, input logic [4:0] a,
                      input logic [15:0] s);
    validA_i = v; pwriteA_i = pw; preadA_i = pr; sreadA_i = sr;
    functionTypeA_i = ft; opcodeA_i = op; primAddrA_i = a; secOperandA_i = s;
  endtask

  task automatic setB(input logic v, input logic pw, input logic pr, input logic sr,
                      input logic [1:0] ft, input logic [6:0] op, input logic [4:0] a,
                      input logic [15:0] s);
    validB_i = v; pwriteB_i = pw; preadB_i = pr; sreadB_i = sr;
    functionTypeB_i = ft; opcodeB_i = op; primAddrB_i = a; secOperandB_i = s;
  endtask

  task automatic setWb(input logic va, input logic [4:0] aa, input logic [15:0] da,
                       input logic vb, input logic [4:0] ab, input logic [15:0] db);
    wbA_i = va; wbAddrA_i = aa; wbDataA_i = da;
    wbB_i = vb; wbAddrB_i = ab; wbDataB_i = db;
  endtask

  task automatic idle();
    setA(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 7'd0, 5'd0, 16'h0000);
    setB(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 7'd0, 5'd0, 16'h0000);
    setWb(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
    flush_i = 1'b0;
  endtask

  task automatic pushA(input logic [6:0] op, input logic [1:0] ft, input logic [4:0] a,
                       input logic wb, input logic [15:0] p, input logic [15:0] s);
    expA.push_back('{op, ft, a, wb, p, s});
  endtask

  task automatic pushB(input logic [6:0] op, input logic [1:0] ft, input logic [4:0] a,
                       input logic wb, input logic [15:0] p, input logic [15:0] s);
    expB.push_back('{op, ft, a, wb, p, s});
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    idle();
    reset_i = 1'b1;
    // Conflicting pair while in reset: stalls must stay low.
    setA(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'h21, 5'd7, 16'h0000);
    setB(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h22, 5'd7, 16'h0000);
    #2;
    check("reset stallB", 64'(stallB_o), 64'd0);
    check("reset validA", 64'(validA_o), 64'd0);
    check("reset bank", 64'(bank_o), 64'd0);
    idle();
    tick();
    reset_i = 1'b0;

    // Direct assignment r3 = 0x1234, then B reads it.
    setA(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 7'd0, 5'd3, 16'h1234);
    pushA(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h1234);
    tick(); idle();
    setB(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h05, 5'd3, 16'h0042);
    #1 check("assign no scoreboard stallB", 64'(stallB_o), 64'd0);
    pushB(7'h05, 2'd0, 5'd3, 1'b0, 16'h1234, 16'h0042);
    tick(); idle();

    // Assignment op10 with register secondary: r4 = r3.
    setA(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 7'd10, 5'd4, 16'h0003);
    pushA(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h1234);
    tick(); idle();
    setA(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h06, 5'd4, 16'h0000);
    pushA(7'h06, 2'd0, 5'd4, 1'b0, 16'h1234, 16'h0000);
    tick(); idle();

    // RAW stall: write r5 then read r5 -> six stalled cycles.
    setA(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'h33, 5'd5, 16'h0007);
    pushA(7'h33, 2'd0, 5'd5, 1'b1, 16'h0000, 16'h0007);
    tick();
    setA(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 7'h10, 5'd5, 16'h0000);
    #1 check("RAW stallB follows stallA", 64'(stallB_o), 64'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("RAW stallA cycle %0d", i + 1), 64'(stallA_o), 64'd1);
      tick();
    end
    check("RAW stallA released", 64'(stallA_o), 64'd0);
    pushA(7'h10, 2'd2, 5'd5, 1'b0, 16'h0000, 16'h0000);
    tick(); idle();

    // RAW again, writeback in cycle 2 releases in cycle 3.
    setA(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'h33, 5'd5, 16'h0007);
    pushA(7'h33, 2'd0, 5'd5, 1'b1, 16'h0000, 16'h0007);
    tick();
    setA(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 7'h10, 5'd5, 16'h0000);
    #1 check("wb RAW stall cycle1", 64'(stallA_o), 64'd1);
    tick();
    setWb(1'b1, 5'd5, 16'h0ABC, 1'b0, 5'd0, 16'h0000);
    #1 check("wb RAW stall cycle2", 64'(stallA_o), 64'd1);
    tick();
    setWb(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
    #1 check("wb RAW released cycle3", 64'(stallA_o), 64'd0);
    pushA(7'h10, 2'd2, 5'd5, 1'b0, 16'h0ABC, 16'h0000);
    tick(); idle();

    // Intra-pair conflict on r7.
    setA(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'h21, 5'd7, 16'h0000);
    setB(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h22, 5'd7, 16'h0000);
    #1 check("pair stallA", 64'(stallA_o), 64'd0);
    check("pair stallB", 64'(stallB_o), 64'd1);
    pushA(7'h21, 2'd0, 5'd7, 1'b1, 16'h0000, 16'h0000);
    tick();
    setA(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 7'd0, 5'd0, 16'h0000);
    #1 check("pair B waits on counter", 64'(stallB_o), 64'd1);
    setWb(1'b0, 5'd0, 16'h0000, 1'b1, 5'd7, 16'h0077);
    tick();
    setWb(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
    #1 check("pair B released", 64'(stallB_o), 64'd0);
    pushB(7'h22, 2'd0, 5'd7, 1'b0, 16'h0077, 16'h0000);
    tick(); idle();

    // Bank ops: 0 -1 -> 63, +1 -> 0, +1/-1 -> 0, +1/+1 -> 2.
    setA(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 7'd21, 5'd0, 16'h0000);
    pushA(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h0000);
    tick(); idle();
    check("bank dec wrap", 64'(bank_o), 64'd63);
    setA(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 7'd20, 5'd0, 16'h0000);
    pushA(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h0000);
    tick(); idle();
    check("bank inc wrap", 64'(bank_o), 64'd0);
    setA(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 7'd20, 5'd0, 16'h0000);
    setB(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 7'd21, 5'd0, 16'h0000);
    pushA(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h0000);
    pushB(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h0000);
    tick(); idle();
    check("bank inc+dec", 64'(bank_o), 64'd0);
    setA(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 7'd20, 5'd0, 16'h0000);
    setB(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 7'd20, 5'd0, 16'h0000);
    pushA(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h0000);
    pushB(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h0000);
    tick(); idle();
    check("bank inc+inc", 64'(bank_o), 64'd2);

    // Flush: stalls forced low, no issue, no load, but writeback lands.
    setA(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'h30, 5'd9, 16'h0000);
    setB(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h31, 5'd9, 16'h0000);
    setWb(1'b1, 5'd9, 16'h0099, 1'b0, 5'd0, 16'h0000);
    flush_i = 1'b1;
    #1 check("flush stallB", 64'(stallB_o), 64'd0);
    tick(); idle();
    setA(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 7'd20, 5'd0, 16'h0000);
    flush_i = 1'b1;
    tick(); idle();
    check("flush blocks bank", 64'(bank_o), 64'd2);
    setA(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h41, 5'd9, 16'h0000);
    #1 check("flush blocks load", 64'(stallA_o), 64'd0);
    pushA(7'h41, 2'd0, 5'd9, 1'b0, 16'h0099, 16'h0000);
    tick(); idle();

    // Forwarding: wbB beats wbA on r2.
    setA(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h40, 5'd2, 16'h0000);
    setWb(1'b1, 5'd2, 16'h0011, 1'b1, 5'd2, 16'h0022);
    pushA(7'h40, 2'd0, 5'd2, 1'b0, 16'h0022, 16'h0000);
    tick(); idle();
    setA(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h41, 5'd2, 16'h0000);
    pushA(7'h41, 2'd0, 5'd2, 1'b0, 16'h0022, 16'h0000);
    tick(); idle();

    // Assignment beats both writebacks on r6.
    setA(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 7'd0, 5'd6, 16'h0666);
    setWb(1'b1, 5'd6, 16'h0AAA, 1'b1, 5'd6, 16'h0BBB);
    pushA(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h0666);
    tick(); idle();
    setA(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h42, 5'd6, 16'h0000);
    pushA(7'h42, 2'd0, 5'd6, 1'b0, 16'h0666, 16'h0000);
    tick(); idle();

    // Reset mid-flight with bank 5 and a pending counter on r10.
    setA(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 7'd20, 5'd0, 16'h0000);
    setB(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 7'd20, 5'd0, 16'h0000);
    pushA(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h0000);
    pushB(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h0000);
    tick(); idle();
    setA(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 7'd20, 5'd0, 16'h0000);
    pushA(7'd0, 2'd0, 5'd0, 1'b0, 16'h0000, 16'h0000);
    tick(); idle();
    check("bank before reset", 64'(bank_o), 64'd5);
    setA(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'h50, 5'd10, 16'h0000);
    pushA(7'h50, 2'd0, 5'd10, 1'b1, 16'h0000, 16'h0000);
    tick(); idle();
    @(negedge clock_i);
    #2 reset_i = 1'b1;
    #1 check("async reset validA", 64'(validA_o), 64'd0);
    check("async reset bank", 64'(bank_o), 64'd0);
    setA(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h60, 5'd10, 16'h0000);
    setB(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'h61, 5'd2, 16'h0000);
    tick();
    reset_i = 1'b0;
    #1 check("post reset stallA", 64'(stallA_o), 64'd0);
    check("post reset stallB", 64'(stallB_o), 64'd0);
    pushA(7'h60, 2'd0, 5'd10, 1'b0, 16'h0000, 16'h0000);
    pushB(7'h61, 2'd0, 5'd2, 1'b0, 16'h0000, 16'h0000);
    tick(); idle();
    tick(); tick();

    check("laneA expectations drained", 64'(expA.size()), 64'd0);
    check("laneB expectations drained", 64'(expB.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
